// File: rtl/led_pattern_sched.sv
// LED bank sequencer: programmable step divider driving four display modes
// (flow-up, flow-down, blink, off) with auto, key and direct-load mode changes.
module led_pattern_sched #(
  parameter int CNT_MAX        = 24_999_999,
  parameter int STEPS_PER_MODE = 8,
  parameter bit AUTO_EN        = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pause,
  input  logic       key_next,
  input  logic       mode_load,
  input  logic [1:0] mode_sel,
  output logic [1:0] led,
  output logic [1:0] mode,
  output logic       step_tick
);

  localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int SW = (STEPS_PER_MODE < 1) ? 1 : $clog2(STEPS_PER_MODE + 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
  localparam logic [SW-1:0] STEP_TOP = SW'(STEPS_PER_MODE - 1);

  typedef enum logic [1:0] {
    FLOW_UP   = 2'd0,
    FLOW_DOWN = 2'd1,
    BLINK     = 2'd2,
    OFF       = 2'd3
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [1:0]    led_q, led_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic          step_tick_q, step_tick_d;
  logic          key_q, key_d;

  logic  key_rise, step, change;
  mode_e target;

  function automatic logic [1:0] entry_pat(input mode_e m);
    case (m)
      FLOW_UP:   entry_pat = 2'b01;
      FLOW_DOWN: entry_pat = 2'b10;
      BLINK:     entry_pat = 2'b11;
      default:   entry_pat = 2'b00;
    endcase
  endfunction

  // With two LEDs a left and a right rotate are both a swap.
  function automatic logic [1:0] next_pat(input mode_e m, input logic [1:0] cur);
    case (m)
      FLOW_UP, FLOW_DOWN: next_pat = {cur[0], cur[1]};
      BLINK:              next_pat = (cur == 2'b11) ? 2'b00 : 2'b11;
      default:            next_pat = 2'b00;
    endcase
  endfunction

  always_comb begin
    mode_d      = mode_q;
    led_d       = led_q;
    cnt_d       = cnt_q;
    step_cnt_d  = step_cnt_q;
    step_tick_d = 1'b0;
    key_d       = key_next;
    change      = 1'b0;
    target      = mode_q;
    key_rise    = key_next & ~key_q;
    step        = ~pause && (cnt_q == CNT_TOP);

    if (mode_load) begin
      change = 1'b1;
      target = mode_e'(mode_sel);
    end else if (key_rise) begin
      change = 1'b1;
      target = mode_e'(2'(mode_q + 2'd1));
    end else if (step) begin
      step_tick_d = 1'b1;
      cnt_d       = '0;
      if (step_cnt_q == STEP_TOP) begin
        step_cnt_d = '0;
        if (AUTO_EN) begin
          change = 1'b1;
          target = mode_e'(2'(mode_q + 2'd1));
        end
      end else begin
        step_cnt_d = SW'(step_cnt_q + 1'b1);
      end
      if (!change) led_d = next_pat(mode_q, led_q);
    end else if (!pause) begin
      cnt_d = CW'(cnt_q + 1'b1);
    end

    // Any mode change restarts the pattern and both counters; an
    // auto-advance keeps the step_tick it already earned.
    if (change) begin
      mode_d     = target;
      led_d      = entry_pat(target);
      cnt_d      = '0;
      step_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      mode_q      <= FLOW_UP;
      led_q       <= 2'b01;
      cnt_q       <= '0;
      step_cnt_q  <= '0;
      step_tick_q <= 1'b0;
      key_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      led_q       <= led_d;
      cnt_q       <= cnt_d;
      step_cnt_q  <= step_cnt_d;
      step_tick_q <= step_tick_d;
      key_q       <= key_d;
    end
  end

  assign led       = led_q;
  assign mode      = mode_q;
  assign step_tick = step_tick_q;

endmodule
